pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter register that generalises the fixed 20-bit load-only PC register. Holds the current instruction address and, under a per-cycle operation code, holds, increments, loads an absolute target, branches relative, or performs call/return through an internal return-address stack. Sits between the control unit, which drives `op`, `target` and `offset`, and instruction memory, which consumes `pc_out`.

## Interface
- `WIDTH`, default 20: PC width in bits.
- `STEP`, default 1: increment amount for INC and for the CALL return address.
- `RESET_VAL`, default 0: PC value after reset.
- `STACK_DEPTH`, default 4: number of return-address entries; must be ≥1.
- `OFF_WIDTH`, default 12: width of the signed branch offset; must be ≤ `WIDTH`.

Ports:
- `clk`  in  1: rising-edge clock; the block's only clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: operation enable; when low, all state holds regardless of `op`.
- `op`  in  3: operation code (see Operation).
- `target`  in  `WIDTH`: absolute address for LOAD and CALL.
- `offset`  in  `OFF_WIDTH`: two's-complement offset for BRANCH.
- `pc_out`  out  `WIDTH`: current PC (the register output).
- `ret_empty`  out  1: return stack holds 0 entries.
- `ret_full`  out  1: return stack holds `STACK_DEPTH` entries.
- `stack_err`  out  1: one-cycle pulse flagging a CALL on a full stack or a RET on an empty stack.

## Operation
- Operation codes:
  - 0 HOLD: PC unchanged.
  - 1 INC: PC ← PC + `STEP`.
  - 2 LOAD: PC ← `target`.
  - 3 BRANCH: PC ← PC + sign-extended `offset`.
  - 4 CALL: push PC + `STEP`, then PC ← `target`.
  - 5 RET: PC ← popped entry.
  - 6 and 7: reserved; behave as HOLD with no error.
- Arithmetic is modulo 2^`WIDTH`, with silent wrap. Examples: 0xFFFFF + 1 → 0x00000; 0x00002 + (−4) → 0xFFFFE.
- The return stack is LIFO with an occupancy count from 0 to `STACK_DEPTH`.
- CALL on a full stack:
  - The jump is still taken.
  - The oldest entry is discarded and the new address pushed, so occupancy stays at `STACK_DEPTH`.
  - `stack_err` pulses.
- RET on an empty stack: PC holds, occupancy stays 0, and `stack_err` pulses.
- `en`=0: PC, stack and occupancy all hold, and `stack_err` is 0 on the next cycle.
- Reset takes effect immediately, including mid-operation:
  - `pc_out` = `RESET_VAL`.
  - Occupancy 0, so `ret_empty`=1 and `ret_full`=0.
  - `stack_err`=0.
  - Stack contents are don't-care.

## Timing
- All state updates on the rising edge of `clk` when `rst_n`=1. The new PC is visible on `pc_out` one cycle after the op is sampled.
- `ret_empty` and `ret_full` decode the registered occupancy, so they update on the same edge as the push or pop.
- `stack_err` is registered: it is high for exactly the one cycle following the offending edge.
- Back-to-back CALL/RET is supported every cycle. A RET directly after a CALL returns the address pushed by that CALL.
- Reset deassertion has no synchronisation requirement beyond system-level release.

## Structure
- Shared package `pc_pkg`:
  - `pc_op_t` enum with OP_HOLD, OP_INC, OP_LOAD, OP_BRANCH, OP_CALL, OP_RET.
  - The 3-bit opcode width constant.
- One sub-module, `pc_ret_stack`:
  - Parameters: `WIDTH`, `STACK_DEPTH`.
  - Inputs: `push`, `pop`, `din`.
  - Outputs: `dout` (top of stack), `empty`, `full`, `err`.
  - Handles drop-oldest on overflow. It is implemented as a circular buffer with top pointer and count.
- Top level `pc_unit`: next-PC mux, adder with offset sign extension, and the PC register.

## Test plan
Defaults unless noted (`WIDTH`=20, `STEP`=1, `STACK_DEPTH`=4, `OFF_WIDTH`=12).
1. Reset and increment: hold `rst_n`=0 → `pc_out`=0, `ret_empty`=1; release and apply INC for 3 cycles → `pc_out` reads 1, 2, 3.
2. Load, wrap and branch:
   - LOAD 0xFFFFF, then INC → 0x00000.
   - BRANCH with `offset`=0xFFC (−4) from 0x00010 → 0x0000C.
   - BRANCH with `offset`=0x7FF from 0 → 0x007FF.
3. Call/return: from PC=0x100, CALL 0x200 then RET → `pc_out` reads 0x200, then 0x101; `ret_empty` reads 0 after the CALL and 1 after the RET.
4. Overflow: 5 nested CALLs from PCs 0x10, 0x20, 0x30, 0x40, 0x50 →
   - `ret_full`=1 after the 4th CALL.
   - `stack_err` pulses once, after the 5th.
   - Then 4 RETs → 0x51, 0x41, 0x31, 0x21, with `ret_empty`=1 after the last.
   - A 5th RET → PC holds and `stack_err` pulses.
5. Enable and reserved ops:
   - `en`=0 with CALL asserted for 3 cycles → PC and occupancy unchanged, `stack_err`=0.
   - `op`=6 or 7 → PC unchanged, no error.
6. Async reset mid-operation: assert `rst_n` low between clock edges with 2 stack entries → `pc_out`=`RESET_VAL` immediately, `ret_empty`=1, and a following RET raises `stack_err`.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: opcode width and encodings.
package pc_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_HOLD   = 3'd0,
        OP_INC    = 3'd1,
        OP_LOAD   = 3'd2,
        OP_BRANCH = 3'd3,
        OP_CALL   = 3'd4,
        OP_RET    = 3'd5
    } pc_op_t;

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address stack: circular buffer with top pointer and occupancy count.
// A push on a full stack overwrites the oldest entry; a pop on an empty stack
// leaves everything unchanged. Both cases raise a one-cycle registered err.
module pc_ret_stack #(
    parameter int unsigned WIDTH       = 20,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             err
);

    localparam int unsigned PW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned CW = $clog2(STACK_DEPTH + 1);

    logic [WIDTH-1:0] r_mem [STACK_DEPTH];
    logic [PW-1:0]    r_top;
    logic [CW-1:0]    r_cnt;
    logic             r_err;

    logic [PW-1:0]    w_top_inc;
    logic [PW-1:0]    w_top_dec;
    logic             w_empty;
    logic             w_full;

    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == CW'(STACK_DEPTH));
    // Pointer wraps explicitly so non-power-of-two depths stay in range.
    assign w_top_inc = (r_top == PW'(STACK_DEPTH - 1)) ? '0 : r_top + PW'(1);
    assign w_top_dec = (r_top == '0) ? PW'(STACK_DEPTH - 1) : r_top - PW'(1);

    // Pointer, occupancy and error flag; overflow keeps the count saturated
    // while the pointer advances onto the oldest slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_top <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= (push & w_full) | (pop & w_empty);
            if (push) begin
                r_top <= w_top_inc;
                if (!w_full) begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else if (pop && !w_empty) begin
                r_top <= w_top_dec;
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    // Entry storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[w_top_inc] <= din;
        end
    end

    assign dout  = r_mem[r_top];
    assign empty = w_empty;
    assign full  = w_full;
    assign err   = r_err;

endmodule

// File: rtl/pc_unit.sv
// Program counter: hold / increment / absolute load / relative branch /
// call and return through an internal return-address stack.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned     WIDTH       = 20,
    parameter int unsigned     STEP        = 1,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter int unsigned     STACK_DEPTH = 4,
    parameter int unsigned     OFF_WIDTH   = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [OP_W-1:0]      op,
    input  logic [WIDTH-1:0]     target,
    input  logic [OFF_WIDTH-1:0] offset,
    output logic [WIDTH-1:0]     pc_out,
    output logic                 ret_empty,
    output logic                 ret_full,
    output logic                 stack_err
);

    logic [WIDTH-1:0]            r_pc;

    logic signed [OFF_WIDTH-1:0] w_off_s;
    logic [WIDTH-1:0]            w_off_ext;
    logic [WIDTH-1:0]            w_pc_step;
    logic [WIDTH-1:0]            w_pc_next;
    logic [WIDTH-1:0]            w_ret_addr;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_empty;
    logic                        w_full;
    logic                        w_err;

    // Signed size cast sign-extends, and stays legal when OFF_WIDTH == WIDTH.
    assign w_off_s   = offset;
    assign w_off_ext = WIDTH'(w_off_s);
    assign w_pc_step = r_pc + WIDTH'(STEP);

    // Next-PC select and stack control; reserved opcodes fall to hold.
    always_comb begin
        w_pc_next = r_pc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        if (en) begin
            case (pc_op_t'(op))
                OP_INC:    w_pc_next = w_pc_step;
                OP_LOAD:   w_pc_next = target;
                OP_BRANCH: w_pc_next = r_pc + w_off_ext;
                OP_CALL: begin
                    w_push    = 1'b1;
                    w_pc_next = target;
                end
                OP_RET: begin
                    w_pop = 1'b1;
                    if (!w_empty) begin
                        w_pc_next = w_ret_addr;
                    end
                end
                default:   w_pc_next = r_pc;
            endcase
        end
    end

    // PC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_VAL;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    pc_ret_stack #(
        .WIDTH       (WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_pc_step),
        .dout  (w_ret_addr),
        .empty (w_empty),
        .full  (w_full),
        .err   (w_err)
    );

    assign pc_out    = r_pc;
    assign ret_empty = w_empty;
    assign ret_full  = w_full;
    assign stack_err = w_err;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: constant vector table feeding a scoreboard queue, plus a
// hand-written asynchronous-reset sequence.
module tb_pc_unit;
    import pc_pkg::*;

    localparam int unsigned W  = 20;
    localparam int unsigned OW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [2:0]    op;
    logic [W-1:0]  target;
    logic [OW-1:0] offset;
    logic [W-1:0]  pc_out;
    logic          ret_empty;
    logic          ret_full;
    logic          stack_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic         en;
        logic [2:0]   op;
        logic [W-1:0] tgt;
        logic [OW-1:0] off;
        logic [W-1:0] pc;
        logic         emp;
        logic         ful;
        logic         err;
    } vec_t;

    typedef struct {
        int           idx;
        logic [W-1:0] pc;
        logic         emp;
        logic         ful;
        logic         err;
    } exp_t;

    exp_t sb[$];

    pc_unit #(
        .WIDTH       (W),
        .STEP        (1),
        .RESET_VAL   (20'h00000),
        .STACK_DEPTH (4),
        .OFF_WIDTH   (OW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .op        (op),
        .target    (target),
        .offset    (offset),
        .pc_out    (pc_out),
        .ret_empty (ret_empty),
        .ret_full  (ret_full),
        .stack_err (stack_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no end, required $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got 0x%0h, required 0x%0h", name, idx, act, exp);
        end
    endtask

    // Drive one op, queue its expectation, then compare once the edge has passed.
    task automatic step(input int idx, input vec_t v);
        exp_t e;
        en     = v.en;
        op     = v.op;
        target = v.tgt;
        offset = v.off;
        e.idx = idx; e.pc = v.pc; e.emp = v.emp; e.ful = v.ful; e.err = v.err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("pc_out",    e.idx, 32'(pc_out),    32'(e.pc));
        chk("ret_empty", e.idx, 32'(ret_empty), 32'(e.emp));
        chk("ret_full",  e.idx, 32'(ret_full),  32'(e.ful));
        chk("stack_err", e.idx, 32'(stack_err), 32'(e.err));
    endtask

    function automatic vec_t mk(input logic e, input logic [2:0] o, input logic [W-1:0] t,
                                input logic [OW-1:0] f, input logic [W-1:0] p,
                                input logic em, input logic fu, input logic er);
        vec_t v;
        v.en = e; v.op = o; v.tgt = t; v.off = f; v.pc = p; v.emp = em; v.ful = fu; v.err = er;
        return v;
    endfunction

    initial begin
        vec_t vt[$];
        vec_t v;

        // Reset and increment
        vt.push_back(mk(1, 3'd1, 20'h0,     12'h0,   20'h00001, 1, 0, 0));
        vt.push_back(mk(1, 3'd1, 20'h0,     12'h0,   20'h00002, 1, 0, 0));
        vt.push_back(mk(1, 3'd1, 20'h0,     12'h0,   20'h00003, 1, 0, 0));
        // Load, wrap, branch
        vt.push_back(mk(1, 3'd2, 20'hFFFFF, 12'h0,   20'hFFFFF, 1, 0, 0));
        vt.push_back(mk(1, 3'd1, 20'h0,     12'h0,   20'h00000, 1, 0, 0));
        vt.push_back(mk(1, 3'd2, 20'h00010, 12'h0,   20'h00010, 1, 0, 0));
        vt.push_back(mk(1, 3'd3, 20'h0,     12'hFFC, 20'h0000C, 1, 0, 0));
        vt.push_back(mk(1, 3'd2, 20'h00000, 12'h0,   20'h00000, 1, 0, 0));
        vt.push_back(mk(1, 3'd3, 20'h0,     12'h7FF, 20'h007FF, 1, 0, 0));
        vt.push_back(mk(1, 3'd2, 20'h00002, 12'h0,   20'h00002, 1, 0, 0));
        vt.push_back(mk(1, 3'd3, 20'h0,     12'hFFC, 20'hFFFFE, 1, 0, 0));
        // Call / return
        vt.push_back(mk(1, 3'd2, 20'h00100, 12'h0,   20'h00100, 1, 0, 0));
        vt.push_back(mk(1, 3'd4, 20'h00200, 12'h0,   20'h00200, 0, 0, 0));
        vt.push_back(mk(1, 3'd5, 20'h0,     12'h0,   20'h00101, 1, 0, 0));
        // Overflow: calls from 0x10..0x50, fifth one drops the oldest entry
        vt.push_back(mk(1, 3'd2, 20'h00010, 12'h0,   20'h00010, 1, 0, 0));
        vt.push_back(mk(1, 3'd4, 20'h00020, 12'h0,   20'h00020, 0, 0, 0));
        vt.push_back(mk(1, 3'd4, 20'h00030, 12'h0,   20'h00030, 0, 0, 0));
        vt.push_back(mk(1, 3'd4, 20'h00040, 12'h0,   20'h00040, 0, 0, 0));
        vt.push_back(mk(1, 3'd4, 20'h00050, 12'h0,   20'h00050, 0, 1, 0));
        vt.push_back(mk(1, 3'd4, 20'h00060, 12'h0,   20'h00060, 0, 1, 1));
        vt.push_back(mk(1, 3'd5, 20'h0,     12'h0,   20'h00051, 0, 0, 0));
        vt.push_back(mk(1, 3'd5, 20'h0,     12'h0,   20'h00041, 0, 0, 0));
        vt.push_back(mk(1, 3'd5, 20'h0,     12'h0,   20'h00031, 0, 0, 0));
        vt.push_back(mk(1, 3'd5, 20'h0,     12'h0,   20'h00021, 1, 0, 0));
        vt.push_back(mk(1, 3'd5, 20'h0,     12'h0,   20'h00021, 1, 0, 1));
        vt.push_back(mk(1, 3'd0, 20'h0,     12'h0,   20'h00021, 1, 0, 0));
        // Enable low and reserved opcodes
        vt.push_back(mk(1, 3'd4, 20'h00300, 12'h0,   20'h00300, 0, 0, 0));
        vt.push_back(mk(0, 3'd4, 20'h00400, 12'h0,   20'h00300, 0, 0, 0));
        vt.push_back(mk(0, 3'd4, 20'h00400, 12'h0,   20'h00300, 0, 0, 0));
        vt.push_back(mk(0, 3'd4, 20'h00400, 12'h0,   20'h00300, 0, 0, 0));
        vt.push_back(mk(1, 3'd6, 20'h00500, 12'h7,   20'h00300, 0, 0, 0));
        vt.push_back(mk(1, 3'd7, 20'h00500, 12'h7,   20'h00300, 0, 0, 0));
        vt.push_back(mk(1, 3'd5, 20'h0,     12'h0,   20'h00022, 1, 0, 0));
        vt.push_back(mk(1, 3'd5, 20'h0,     12'h0,   20'h00022, 1, 0, 1));
        vt.push_back(mk(0, 3'd5, 20'h0,     12'h0,   20'h00022, 1, 0, 0));
        // Back-to-back call then return
        vt.push_back(mk(1, 3'd4, 20'h00500, 12'h0,   20'h00500, 0, 0, 0));
        vt.push_back(mk(1, 3'd5, 20'h0,     12'h0,   20'h00023, 1, 0, 0));
        // Set up two entries before the asynchronous reset
        vt.push_back(mk(1, 3'd2, 20'h00700, 12'h0,   20'h00700, 1, 0, 0));
        vt.push_back(mk(1, 3'd4, 20'h00710, 12'h0,   20'h00710, 0, 0, 0));
        vt.push_back(mk(1, 3'd4, 20'h00720, 12'h0,   20'h00720, 0, 0, 0));

        rst_n = 1'b0; en = 1'b0; op = 3'd0; target = '0; offset = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset pc_out",    -1, 32'(pc_out),    32'h0);
        chk("reset ret_empty", -1, 32'(ret_empty), 32'h1);
        chk("reset ret_full",  -1, 32'(ret_full),  32'h0);
        chk("reset stack_err", -1, 32'(stack_err), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            step(i, vt[i]);
        end

        // Asynchronous reset between edges while a CALL is being presented
        en = 1'b1; op = 3'd4; target = 20'h00999;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async pc_out",    100, 32'(pc_out),    32'h0);
        chk("async ret_empty", 100, 32'(ret_empty), 32'h1);
        chk("async ret_full",  100, 32'(ret_full),  32'h0);
        chk("async stack_err", 100, 32'(stack_err), 32'h0);
        @(posedge clk);
        #1;
        chk("held pc_out", 101, 32'(pc_out), 32'h0);
        rst_n = 1'b1;
        v = mk(1, 3'd5, 20'h0, 12'h0, 20'h00000, 1, 0, 1);
        step(102, v);
        v = mk(1, 3'd1, 20'h0, 12'h0, 20'h00001, 1, 0, 0);
        step(103, v);

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: %0d entries left, required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
